// File: rtl/bbox_finder.sv
// Scans a stored 24-bit RGB image and reports the bounding box of dark pixels.
// Optional macro BBOX_MARGIN_EN pads the reported box by MARGIN per side, clamped to the image.
module bbox_finder #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int THRESH = 384,
  parameter int MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic [23:0] readAddr,
  input  logic [15:0] readdata,
  output logic [10:0] xMin,
  output logic [10:0] xMax,
  output logic [10:0] yMin,
  output logic [10:0] yMax,
  output logic        found
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_ACC, S_EVAL, S_FINISHED} state_t;

  state_t      r_state, w_next;
  logic [10:0] r_x, r_y;
  logic [1:0]  r_rgb;
  logic [9:0]  r_sum;
  logic [10:0] r_bxMin, r_bxMax, r_byMin, r_byMax;
  logic        r_bfound;

  logic        w_clear, w_hit, w_last, w_nfound, w_unused;
  logic [10:0] w_nxMin, w_nxMax, w_nyMin, w_nyMax;
  logic [10:0] w_oxMin, w_oxMax, w_oyMin, w_oyMax;

  assign w_clear  = ((r_state == S_IDLE) || (r_state == S_FINISHED)) && start;
  assign w_hit    = r_sum < 10'(THRESH);
  assign w_last   = (r_x == 11'(WIDTH - 1)) && (r_y == 11'(HEIGHT - 1));
  assign done     = (r_state == S_FINISHED);
  assign readAddr = 24'(r_x) * 24'(HEIGHT * 3) + 24'(r_y) * 24'd3 + 24'(r_rgb);

  // Running box including the pixel being evaluated this cycle.
  assign w_nxMin  = (w_hit && (r_x < r_bxMin)) ? r_x : r_bxMin;
  assign w_nxMax  = (w_hit && (r_x > r_bxMax)) ? r_x : r_bxMax;
  assign w_nyMin  = (w_hit && (r_y < r_byMin)) ? r_y : r_byMin;
  assign w_nyMax  = (w_hit && (r_y > r_byMax)) ? r_y : r_byMax;
  assign w_nfound = r_bfound | w_hit;

`ifdef BBOX_MARGIN_EN
  assign w_unused = ^readdata[15:8];

  always_comb begin
    int v;
    v       = int'(w_nxMin) - MARGIN;
    w_oxMin = (v < 0) ? '0 : 11'(v);
    v       = int'(w_nxMax) + MARGIN;
    w_oxMax = (v > WIDTH - 1) ? 11'(WIDTH - 1) : 11'(v);
    v       = int'(w_nyMin) - MARGIN;
    w_oyMin = (v < 0) ? '0 : 11'(v);
    v       = int'(w_nyMax) + MARGIN;
    w_oyMax = (v > HEIGHT - 1) ? 11'(HEIGHT - 1) : 11'(v);
  end
`else
  assign w_unused = ^readdata[15:8] ^ (MARGIN != 0);
  assign w_oxMin  = w_nxMin;
  assign w_oxMax  = w_nxMax;
  assign w_oyMin  = w_nyMin;
  assign w_oyMax  = w_nyMax;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_READ;
      S_READ:     w_next = S_ACC;
      S_ACC:      w_next = (r_rgb == 2'd2) ? S_EVAL : S_READ;
      S_EVAL:     w_next = w_last ? S_FINISHED : S_READ;
      S_FINISHED: if (start) w_next = S_READ;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rgb    <= '0;
      r_sum    <= '0;
      r_bxMin  <= '0;
      r_bxMax  <= '0;
      r_byMin  <= '0;
      r_byMax  <= '0;
      r_bfound <= 1'b0;
      xMin     <= '0;
      xMax     <= '0;
      yMin     <= '0;
      yMax     <= '0;
      found    <= 1'b0;
    end else if (w_clear) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rgb    <= '0;
      r_sum    <= '0;
      r_bxMin  <= 11'(WIDTH - 1);
      r_bxMax  <= '0;
      r_byMin  <= 11'(HEIGHT - 1);
      r_byMax  <= '0;
      r_bfound <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          r_sum <= r_sum + {2'b00, readdata[7:0]};
          if (r_rgb != 2'd2) r_rgb <= r_rgb + 2'd1;
        end
        S_EVAL: begin
          r_bxMin  <= w_nxMin;
          r_bxMax  <= w_nxMax;
          r_byMin  <= w_nyMin;
          r_byMax  <= w_nyMax;
          r_bfound <= w_nfound;
          r_sum    <= '0;
          r_rgb    <= '0;
          if (r_y == 11'(HEIGHT - 1)) begin
            r_y <= '0;
            r_x <= w_last ? '0 : r_x + 11'd1;
          end else begin
            r_y <= r_y + 11'd1;
          end
          if (w_last) begin
            found <= w_nfound;
            xMin  <= w_nfound ? w_oxMin : '0;
            xMax  <= w_nfound ? w_oxMax : '0;
            yMin  <= w_nfound ? w_oyMin : '0;
            yMax  <= w_nfound ? w_oyMax : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_finder.sv
// Scoreboard bench for bbox_finder on a 4x3 image: expected boxes are queued at start
// and compared when done rises; read addresses and scan length are checked per scan.
module tb_bbox_finder;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int TH  = 384;
  localparam int MG  = 1;
  localparam int N   = W * H;
  localparam int CYC = N * 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done, found;
  logic [23:0] readAddr;
  logic [15:0] readdata = '0;
  logic [10:0] xMin, xMax, yMin, yMax;

  logic [7:0]  mem [0:N*3-1];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    bit f;
    int x0, x1, y0, y1;
  } exp_t;

  exp_t sb[$];
  exp_t prev;
  exp_t zero;

  bbox_finder #(.WIDTH(W), .HEIGHT(H), .THRESH(TH), .MARGIN(MG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .readAddr(readAddr),
    .readdata(readdata), .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax), .found(found)
  );

  always #5 clk = ~clk;

  // One-cycle read latency; the upper byte carries junk that must be ignored.
  always @(posedge clk) begin
    if (int'(readAddr) < N * 3) readdata <= {8'hA5, mem[int'(readAddr)]};
    else                        readdata <= 16'hA5FF;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".found"}, int'(found), int'(e.f));
    check({tag, ".xMin"}, int'(xMin), e.x0);
    check({tag, ".xMax"}, int'(xMax), e.x1);
    check({tag, ".yMin"}, int'(yMin), e.y0);
    check({tag, ".yMax"}, int'(yMax), e.y1);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N * 3; i++) mem[i] = 8'(v);
  endtask

  task automatic set_px(input int x, input int y, input int r, input int g, input int b);
    mem[x*H*3 + y*3 + 0] = 8'(r);
    mem[x*H*3 + y*3 + 1] = 8'(g);
    mem[x*H*3 + y*3 + 2] = 8'(b);
  endtask

  function automatic exp_t model();
    exp_t e;
    int   s;
    e.f = 1'b0; e.x0 = W - 1; e.x1 = 0; e.y0 = H - 1; e.y1 = 0;
    for (int x = 0; x < W; x++) begin
      for (int y = 0; y < H; y++) begin
        s = int'(mem[x*H*3 + y*3]) + int'(mem[x*H*3 + y*3 + 1]) + int'(mem[x*H*3 + y*3 + 2]);
        if (s < TH) begin
          e.f = 1'b1;
          if (x < e.x0) e.x0 = x;
          if (x > e.x1) e.x1 = x;
          if (y < e.y0) e.y0 = y;
          if (y > e.y1) e.y1 = y;
        end
      end
    end
    if (!e.f) begin
      e.x0 = 0; e.x1 = 0; e.y0 = 0; e.y1 = 0;
    end else begin
`ifdef BBOX_MARGIN_EN
      e.x0 = (e.x0 - MG < 0) ? 0 : e.x0 - MG;
      e.x1 = (e.x1 + MG > W - 1) ? W - 1 : e.x1 + MG;
      e.y0 = (e.y0 - MG < 0) ? 0 : e.y0 - MG;
      e.y1 = (e.y1 + MG > H - 1) ? H - 1 : e.y1 + MG;
`endif
    end
    return e;
  endfunction

  // k counts clock edges after the start-accept edge; sampled 1 time unit after each edge.
  task automatic run_scan(input bit mid_start, input int rst_at);
    exp_t e;
    int   k;
    bit   aborted;
    aborted = 1'b0;
    sb.push_back(model());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k <= CYC + 20 && !aborted) begin
      if (k < CYC && (k % 7) < 6 && (k % 7) % 2 == 0)
        check("readAddr", int'(readAddr), (k / 7) * 3 + (k % 7) / 2);
      if (k == 42) check_outs("hold", prev);
      if (mid_start && k == 20) start = 1'b1;
      if (k == 21) start = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst.done", int'(done), 0);
        check("rst.readAddr", int'(readAddr), 0);
        check_outs("rst", zero);
        void'(sb.pop_front());
        prev = zero;
        #2 rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!aborted) begin
      e = sb.pop_front();
      check("cycles", k, CYC);
      check("done", int'(done), 1);
      check_outs("result", e);
      prev = e;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero = '{f: 1'b0, x0: 0, x1: 0, y0: 0, y1: 0};
    prev = zero;
    fill(255);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("init.done", int'(done), 0);
    check("init.readAddr", int'(readAddr), 0);
    check_outs("init", zero);

    run_scan(1'b0, 0);

    set_px(2, 1, 0, 0, 0);
    run_scan(1'b0, 0);

    fill(255);
    set_px(0, 2, 0, 0, 0);
    set_px(3, 0, 0, 0, 0);
    run_scan(1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("held.done", int'(done), 1);
    check_outs("held", prev);

    fill(255);
    set_px(1, 1, 128, 128, 128);
    run_scan(1'b0, 0);
    set_px(1, 1, 128, 128, 127);
    run_scan(1'b0, 0);

    fill(255);
    set_px(2, 1, 0, 0, 0);
    run_scan(1'b0, 40);
    run_scan(1'b1, 0);

    fill(255);
    set_px(0, 0, 10, 20, 30);
    run_scan(1'b0, 0);
    fill(255);
    set_px(3, 2, 0, 0, 0);
    run_scan(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
